// File: rtl/sd_cmd_if.sv
// SD SPI-mode command engine: sends one 48-bit command, captures R1 and optionally one 512-byte block.
// Define SD_CMD_CRC_EN to generate CRC7 internally; otherwise cmd_crc is sent as supplied.
module sd_cmd_if #(
  parameter int CLK_DIV   = 2,
  parameter int RESP_TMO  = 64,
  parameter int TOKEN_TMO = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_idx,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  input  logic        rd_blk,
  output logic        busy,
  output logic        done,
  output logic [7:0]  resp,
  output logic        timeout,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        SD_CLK,
  output logic        SD_CS_n,
  output logic        SD_MOSI,
  input  logic        SD_MISO
);

  typedef enum logic [2:0] {
    IDLE, SEND, WAIT_R1, RECV_R1, WAIT_TOK, RECV_DAT, RECV_CRC, FIN
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic [15:0] cnt_q, cnt_d;
  logic [9:0]  byte_q, byte_d;
  logic [7:0]  sh_q, sh_d;
  logic [47:0] frame_q, frame_d;
  logic        rd_blk_q, rd_blk_d;
  logic [7:0]  resp_q, resp_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic [6:0]  crc7;

`ifdef SD_CMD_CRC_EN
  function automatic logic [6:0] crc7_f(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  logic unused_cmd_crc;
  assign unused_cmd_crc = ^cmd_crc;
  assign crc7 = crc7_f({2'b01, cmd_idx, cmd_arg});
`else
  assign crc7 = cmd_crc;
`endif

  logic       active, tick, rise, fall;
  logic [7:0] sample_byte;

  // SD_CLK only runs while bits are moving; every exit to FIN happens on a rising edge, so it parks high.
  assign active      = (state_q != IDLE) && (state_q != FIN);
  assign tick        = active && (div_q == 8'(CLK_DIV - 1));
  assign rise        = tick && !sclk_q;
  assign fall        = tick && sclk_q;
  assign sample_byte = {sh_q[6:0], SD_MISO};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      sclk_q     <= 1'b1;
      mosi_q     <= 1'b1;
      cnt_q      <= '0;
      byte_q     <= '0;
      sh_q       <= 8'hFF;
      frame_q    <= '0;
      rd_blk_q   <= 1'b0;
      resp_q     <= 8'hFF;
      timeout_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      sh_q       <= sh_d;
      frame_q    <= frame_d;
      rd_blk_q   <= rd_blk_d;
      resp_q     <= resp_d;
      timeout_q  <= timeout_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = 8'd0;
    sclk_d     = 1'b1;
    mosi_d     = mosi_q;
    cnt_d      = cnt_q;
    byte_d     = byte_q;
    sh_d       = sh_q;
    frame_d    = frame_q;
    rd_blk_d   = rd_blk_q;
    resp_d     = resp_q;
    timeout_d  = timeout_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    if (active) begin
      div_d  = tick ? 8'd0 : div_q + 8'd1;
      sclk_d = tick ? ~sclk_q : sclk_q;
    end

    if (fall) begin
      mosi_d = (state_q == SEND) ? frame_q[47] : 1'b1;
      if (state_q == SEND) begin
        frame_d = {frame_q[46:0], 1'b1};
        cnt_d   = cnt_q + 16'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          state_d   = SEND;
          frame_d   = {2'b01, cmd_idx, cmd_arg, crc7, 1'b1};
          rd_blk_d  = rd_blk;
          timeout_d = 1'b0;
          cnt_d     = '0;
          byte_d    = '0;
        end
      end
      SEND: begin
        if (rise && cnt_q == 16'd48) begin
          state_d = WAIT_R1;
          cnt_d   = '0;
        end
      end
      WAIT_R1: begin
        if (rise) begin
          if (!SD_MISO) begin
            sh_d    = sample_byte;
            state_d = RECV_R1;
            cnt_d   = '0;
          end else if (cnt_q == 16'(RESP_TMO - 1)) begin
            resp_d    = 8'hFF;
            timeout_d = 1'b1;
            state_d   = FIN;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      RECV_R1: begin
        if (rise) begin
          sh_d = sample_byte;
          if (cnt_q == 16'd6) begin
            resp_d = sample_byte;
            cnt_d  = '0;
            if (rd_blk_q && sample_byte == 8'h00) begin
              state_d = WAIT_TOK;
              sh_d    = 8'hFF;
            end else begin
              state_d = FIN;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      WAIT_TOK: begin
        if (rise) begin
          sh_d = sample_byte;
          if (sample_byte == 8'hFE) begin
            state_d = RECV_DAT;
            cnt_d   = '0;
            byte_d  = '0;
          end else if (cnt_q == 16'(TOKEN_TMO - 1)) begin
            timeout_d = 1'b1;
            state_d   = FIN;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      RECV_DAT: begin
        if (rise) begin
          sh_d = sample_byte;
          if (cnt_q == 16'd7) begin
            cnt_d      = '0;
            rd_data_d  = sample_byte;
            rd_valid_d = 1'b1;
            if (byte_q == 10'd511) state_d = RECV_CRC;
            else                   byte_d  = byte_q + 10'd1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      RECV_CRC: begin
        if (rise) begin
          if (cnt_q == 16'd15) state_d = FIN;
          else                 cnt_d   = cnt_q + 16'd1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);
  assign SD_CS_n  = (state_q == IDLE);
  assign SD_CLK   = sclk_q;
  assign SD_MOSI  = mosi_q;
  assign resp     = resp_q;
  assign timeout  = timeout_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: doc/sd_cmd_if.md
SD_CMD_IF -- requirements
Module: sd_cmd_if

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: SD_CLK half-period in clk cycles, legal range 1..255.
REQ-002 SHALL have parameter RESP_TMO, default 64: maximum SD_CLK rising edges to wait for the R1 start bit.
REQ-003 SHALL have parameter TOKEN_TMO, default 8192: maximum SD_CLK rising edges to wait for the 0xFE data token.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- cmd_start  in  1  one-clk request, accepted only while busy=0.
- cmd_idx  in  6  command index.
- cmd_arg  in  32  command argument.
- cmd_crc  in  7  supplied CRC7.
- rd_blk  in  1  a 512-byte data block follows a 0x00 R1.
- busy  out  1  transaction in progress.
- done  out  1  one-clk completion pulse.
- resp  out  8  captured R1.
- timeout  out  1  R1 or token timeout, valid with done.
- rd_data  out  8  received data byte.
- rd_valid  out  1  one-clk strobe per data byte.
- SD_CLK  out  1  card clock, idles high.
- SD_CS_n  out  1  card select.
- SD_MOSI  out  1  to card SD_IN.
- SD_MISO  in  1  from card SD_OUT.
REQ-005 SHALL use one clock, clk; reset rst_n is asynchronous and active-low.

Function
REQ-006 SHALL implement states IDLE, SEND, WAIT_R1, RECV_R1, WAIT_TOK, RECV_DAT, RECV_CRC, FIN.
REQ-007 When cmd_start=1 in IDLE, SHALL latch all inputs, assert busy and drive SD_CS_n=0 on the next clk, and enter SEND; cmd_start while busy=1 SHALL be ignored.
REQ-008 SHALL toggle SD_CLK every CLK_DIV clk cycles in all states except IDLE and FIN, and SHALL hold it high otherwise.
REQ-009 SHALL change SD_MOSI only on SD_CLK falling edges and sample SD_MISO only on SD_CLK rising edges.
REQ-010 SEND: SHALL shift the 48-bit frame {2'b01, cmd_idx, cmd_arg, crc7, 1'b1} MSB first, one bit per SD_CLK; after bit 0, SD_MOSI SHALL be 1 and the state SHALL be WAIT_R1.
REQ-011 WAIT_R1: the first sampled 0 SHALL be R1 bit 7; SHALL capture 7 further bits in RECV_R1 into resp.
REQ-012 If RESP_TMO rising edges pass in WAIT_R1 without a 0, SHALL set resp=8'hFF and timeout=1, and go to FIN.
REQ-013 After R1: if rd_blk=1 and resp=8'h00, SHALL enter WAIT_TOK; otherwise SHALL go to FIN. A nonzero R1 SHALL skip the data phase.
REQ-014 WAIT_TOK: SHALL keep an 8-bit sliding shift register; a value of 8'hFE SHALL start RECV_DAT byte-aligned at the next bit. If TOKEN_TMO edges pass first, SHALL set timeout=1 and go to FIN.
REQ-015 RECV_DAT: SHALL assemble bytes MSB first and pulse rd_valid for one clk with rd_data per byte, exactly 512 times (10-bit counter, no wrap past 511).
REQ-016 RECV_CRC: SHALL clock in 16 bits and discard them, with no rd_valid pulses.
REQ-017 FIN: SHALL pulse done for one clk, then set SD_CS_n=1 and busy=0 and return to IDLE on the following clk.
REQ-018 resp and timeout SHALL hold until the next accepted cmd_start, which clears timeout.

Reset
REQ-019 While rst_n=0, regardless of clk, SHALL force: state IDLE, busy=0, done=0, timeout=0, resp=8'hFF, rd_data=0, rd_valid=0, SD_CLK=1, SD_CS_n=1, SD_MOSI=1, all counters 0.
REQ-020 A reset mid-transaction SHALL abort it with no done pulse; the first cmd_start after reset release SHALL be accepted normally.

Configuration
REQ-021 Macro SD_CMD_CRC_EN: when defined, crc7 SHALL be computed internally (polynomial x^7+x^3+1, init 0) over the first 40 frame bits and cmd_crc SHALL be ignored; when undefined, crc7=cmd_crc with no CRC logic.

Verification
REQ-022 CMD0 (idx 0, arg 0, crc 7'h4A) -> SD_MOSI frame 48'h400000000095; card answers 0x01 -> resp=8'h01, timeout=0, one done pulse.
REQ-023 SD_MISO held 1 after CMD55 -> done after exactly 64 rising edges in WAIT_R1, resp=8'hFF, timeout=1.
REQ-024 CMD17 with rd_blk=1, R1=0x00, token 0xFE, 512 random bytes, 2 CRC bytes -> 512 rd_valid pulses with matching rd_data, then done.
REQ-025 With SD_CMD_CRC_EN, CMD8 arg 32'h000001AA and cmd_crc=0 -> frame ends 8'h87; without it, cmd_crc=7'h43 -> same frame.
REQ-026 rst_n pulsed low at bit 20 of SEND -> SD_CS_n=1, SD_CLK=1, busy=0 immediately, no done pulse; a following CMD0 completes with resp=8'h01.
REQ-027 cmd_start pulsed while busy=1 -> ignored, frame unchanged; R1=0x05 with rd_blk=1 -> no data phase, done with resp=8'h05.
